// File: rtl/mem_rw_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// mem_arb_pkg : shared types and default widths for the main-memory arbiter
// Revision    : 1.0
// ============================================================================
package mem_arb_pkg;

    // Keep these in step with the main_mem address/data widths in global.svh.
    localparam int DEF_AW = 8;
    localparam int DEF_DW = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/mem_rw_arbiter_if.sv
`default_nettype none
// ============================================================================
// mem_rw_arbiter_if : requester-side and memory-side bus of the arbiter
// Revision          : 1.0
// ============================================================================
interface mem_rw_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int AW   = DEF_AW,
    parameter int DW   = DEF_DW
);
    logic [NREQ-1:0]         req_val_i;
    logic [NREQ-1:0]         req_wen_i;
    logic [NREQ-1:0][AW-1:0] req_addr_i;
    logic [NREQ-1:0][DW-1:0] req_wdata_i;
    logic [NREQ-1:0]         req_lock_i;
    logic [NREQ-1:0]         req_rdy_o;
    logic [NREQ-1:0]         rsp_val_o;
    logic [DW-1:0]           rsp_data_o;
    logic                    mem_val_o;
    logic                    mem_wen_o;
    logic [AW-1:0]           mem_addr_o;
    logic [DW-1:0]           mem_wdata_o;
    logic                    mem_rdy_i;
    logic [DW-1:0]           mem_rdata_i;
    logic [NREQ-1:0]         gnt_o;
    logic                    busy_o;

    modport slave (
        input  req_val_i, req_wen_i, req_addr_i, req_wdata_i, req_lock_i,
        input  mem_rdy_i, mem_rdata_i,
        output req_rdy_o, rsp_val_o, rsp_data_o,
        output mem_val_o, mem_wen_o, mem_addr_o, mem_wdata_o,
        output gnt_o, busy_o
    );

    modport master (
        output req_val_i, req_wen_i, req_addr_i, req_wdata_i, req_lock_i,
        output mem_rdy_i, mem_rdata_i,
        input  req_rdy_o, rsp_val_o, rsp_data_o,
        input  mem_val_o, mem_wen_o, mem_addr_o, mem_wdata_o,
        input  gnt_o, busy_o
    );
endinterface
`default_nettype wire

// File: rtl/mem_rw_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// rr_picker : combinational round-robin picker, searches upward from ptr_i
// Revision  : 1.0
// ============================================================================
module rr_picker #(
    parameter int N  = 3,
    parameter int IW = $clog2(N)
) (
    input  wire logic [N-1:0]  req_i,
    input  wire logic [IW-1:0] ptr_i,
    output logic      [N-1:0]  gnt_o,
    output logic      [IW-1:0] idx_o,
    output logic               any_o
);
    int   w_pos;
    logic w_found;

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        w_found = 1'b0;
        w_pos   = 0;
        for (int i = 0; i < N; i++) begin
            w_pos = (int'(ptr_i) + i) % N;
            if (!w_found && req_i[w_pos]) begin
                w_found       = 1'b1;
                gnt_o[w_pos]  = 1'b1;
                idx_o         = IW'(w_pos);
            end
        end
        any_o = w_found;
    end
endmodule
`default_nettype wire

// File: rtl/mem_rw_arbiter.sv
`default_nettype none
// ============================================================================
// mem_rw_arbiter : round-robin owner of the main_mem rw port with short locks
// Revision       : 1.0
// ============================================================================
module mem_rw_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NREQ     = 3,
    parameter int AW       = DEF_AW,
    parameter int DW       = DEF_DW,
    parameter int MAX_HOLD = 15
) (
    input wire logic         clk_i,
    input wire logic         rst_ni,
    mem_rw_arbiter_if.slave  bus
);
    localparam int IW = $clog2(NREQ);

    arb_state_e      r_state, w_state_nxt;
    logic [NREQ-1:0] r_gnt, w_gnt_nxt;
    logic [IW-1:0]   r_gnt_idx, w_gnt_idx_nxt;
    logic [IW-1:0]   r_ptr, w_ptr_nxt;
    logic [7:0]      r_hold_cnt, w_hold_cnt_nxt;
    logic            r_rd_pend, w_rd_pend_nxt;

    logic [NREQ-1:0] w_pick_oh;
    logic [IW-1:0]   w_pick_idx;
    logic            w_pick_any;

    rr_picker #(.N(NREQ), .IW(IW)) u_picker (
        .req_i (bus.req_val_i),
        .ptr_i (r_ptr),
        .gnt_o (w_pick_oh),
        .idx_o (w_pick_idx),
        .any_o (w_pick_any)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state    <= IDLE;
            r_gnt      <= '0;
            r_gnt_idx  <= '0;
            r_ptr      <= '0;
            r_hold_cnt <= 8'd0;
            r_rd_pend  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_gnt      <= w_gnt_nxt;
            r_gnt_idx  <= w_gnt_idx_nxt;
            r_ptr      <= w_ptr_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
            r_rd_pend  <= w_rd_pend_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_gnt_nxt      = r_gnt;
        w_gnt_idx_nxt  = r_gnt_idx;
        w_ptr_nxt      = r_ptr;
        w_hold_cnt_nxt = r_hold_cnt;
        w_rd_pend_nxt  = r_rd_pend;
        case (r_state)
            IDLE: begin
                if (w_pick_any) begin
                    w_state_nxt   = BUSY;
                    w_gnt_nxt     = w_pick_oh;
                    w_gnt_idx_nxt = w_pick_idx;
                end
            end
            BUSY: begin
                if (bus.req_val_i[r_gnt_idx] && bus.mem_rdy_i) begin
                    w_state_nxt   = RESP;
                    w_rd_pend_nxt = ~bus.req_wen_i[r_gnt_idx];
                end else if (!bus.req_val_i[r_gnt_idx]) begin
                    // Withdrawn request: give up ownership without moving the pointer.
                    w_state_nxt    = IDLE;
                    w_gnt_nxt      = '0;
                    w_hold_cnt_nxt = 8'd0;
                end
            end
            RESP: begin
                if (bus.req_lock_i[r_gnt_idx] && bus.req_val_i[r_gnt_idx] &&
                    (r_hold_cnt < 8'(MAX_HOLD))) begin
                    w_state_nxt    = BUSY;
                    w_hold_cnt_nxt = r_hold_cnt + 8'd1;
                end else begin
                    w_state_nxt    = IDLE;
                    w_gnt_nxt      = '0;
                    w_hold_cnt_nxt = 8'd0;
                    w_ptr_nxt      = (r_gnt_idx == IW'(NREQ - 1)) ? '0 : r_gnt_idx + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        bus.mem_val_o   = 1'b0;
        bus.mem_wen_o   = 1'b0;
        bus.mem_addr_o  = {AW{1'b0}};
        bus.mem_wdata_o = {DW{1'b0}};
        bus.req_rdy_o   = '0;
        bus.rsp_val_o   = '0;
        case (r_state)
            BUSY: begin
                bus.mem_val_o   = bus.req_val_i[r_gnt_idx];
                bus.mem_wen_o   = bus.req_wen_i[r_gnt_idx];
                bus.mem_addr_o  = bus.req_addr_i[r_gnt_idx];
                bus.mem_wdata_o = bus.req_wdata_i[r_gnt_idx];
                bus.req_rdy_o   = r_gnt & {NREQ{bus.mem_rdy_i}};
            end
            RESP: begin
                bus.rsp_val_o = r_gnt & {NREQ{r_rd_pend}};
            end
            default: begin
            end
        endcase
    end

    assign bus.gnt_o      = r_gnt;
    assign bus.busy_o     = (r_state != IDLE);
    assign bus.rsp_data_o = bus.mem_rdata_i;

endmodule
`default_nettype wire

// File: tb/tb_mem_rw_arbiter.sv
`default_nettype none
// Self-checking bench for mem_rw_arbiter: single-transaction vector table,
// contention/lock/backpressure/reset/withdrawal sequences and a response scoreboard.
module tb_mem_rw_arbiter;
    logic clk;
    logic rst_n;

    mem_rw_arbiter_if #(.NREQ(3), .AW(8), .DW(16)) bus ();

    mem_rw_arbiter #(.NREQ(3), .AW(8), .DW(16), .MAX_HOLD(2)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural main_mem: one-cycle registered read, write on accept.
    logic [15:0] mem [0:255];
    always @(posedge clk) begin
        if (bus.mem_val_o && bus.mem_rdy_i) begin
            if (bus.mem_wen_o) mem[bus.mem_addr_o] <= bus.mem_wdata_o;
            else               bus.mem_rdata_i    <= mem[bus.mem_addr_o];
        end
    end

    typedef struct {
        int          id;
        logic        wen;
        logic [7:0]  addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
    } vec_t;

    typedef struct {
        int          id;
        logic [15:0] data;
    } rsp_t;

    int   checks   = 0;
    int   failures = 0;
    rsp_t sb[$];
    vec_t vecs[6];
    int   exp_order[8];
    int   exp_gap[8];
    logic [15:0] exp_data[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && (bus.rsp_val_o != 3'b000)) begin
            rsp_t e;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected: got rsp_val 0x%0h expected none", bus.rsp_val_o);
            end else begin
                e = sb.pop_front();
                if (bus.rsp_val_o !== 3'(1 << e.id) || bus.rsp_data_o !== e.data) begin
                    failures++;
                    $display("FAIL sb_rsp: got val 0x%0h data 0x%0h expected val 0x%0h data 0x%0h",
                             bus.rsp_val_o, bus.rsp_data_o, 3'(1 << e.id), e.data);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drop_all();
        bus.req_val_i  = '0;
        bus.req_lock_i = '0;
        bus.req_wen_i  = '0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy_o && n < 20) begin
            step();
            n++;
        end
        chk("wait_idle", 32'(bus.busy_o), 32'd0);
    endtask

    task automatic run_single(input vec_t v);
        wait_idle();
        bus.req_val_i[v.id]   = 1'b1;
        bus.req_wen_i[v.id]   = v.wen;
        bus.req_addr_i[v.id]  = v.addr;
        bus.req_wdata_i[v.id] = v.wdata;
        step();
        chk("single_gnt",     32'(bus.gnt_o),      32'(1 << v.id));
        chk("single_memval",  32'(bus.mem_val_o),  32'd1);
        chk("single_addr",    32'(bus.mem_addr_o), 32'(v.addr));
        chk("single_wen",     32'(bus.mem_wen_o),  32'(v.wen));
        chk("single_rdy",     32'(bus.req_rdy_o),  32'(1 << v.id));
        if (v.wen) chk("single_wdata", 32'(bus.mem_wdata_o), 32'(v.wdata));
        else       sb.push_back('{id: v.id, data: v.rdata});
        step();
        drop_all();
        chk("single_rspval",  32'(bus.rsp_val_o),  v.wen ? 32'd0 : 32'(1 << v.id));
        chk("single_memval2", 32'(bus.mem_val_o),  32'd0);
        step();
        chk("single_idle",    32'(bus.busy_o),     32'd0);
        chk("single_gnt0",    32'(bus.gnt_o),      32'd0);
    endtask

    // Requests are already driven; checks grant order and accept spacing.
    task automatic observe(input int n);
        int k = 0, cyc = 0, last = 0;
        while (k < n && cyc < 60) begin
            step();
            cyc++;
            if (bus.mem_val_o && bus.mem_rdy_i) begin
                chk("obs_gnt", 32'(bus.gnt_o), 32'(1 << exp_order[k]));
                if (k > 0) chk("obs_gap", 32'(cyc - last), 32'(exp_gap[k]));
                sb.push_back('{id: exp_order[k], data: exp_data[k]});
                last = cyc;
                k++;
            end
        end
        chk("obs_count", 32'(k), 32'(n));
        step();
        drop_all();
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{0, 1'b1, 8'h10, 16'h1234, 16'h0000};
        vecs[1] = '{1, 1'b1, 8'h11, 16'hA5A5, 16'h0000};
        vecs[2] = '{0, 1'b0, 8'h10, 16'h0000, 16'h1234};
        vecs[3] = '{2, 1'b0, 8'h11, 16'h0000, 16'hA5A5};
        vecs[4] = '{1, 1'b1, 8'h10, 16'h0F0F, 16'h0000};
        vecs[5] = '{2, 1'b0, 8'h10, 16'h0000, 16'h0F0F};

        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[8'h12] = 16'h5555;
        drop_all();
        bus.req_addr_i  = '0;
        bus.req_wdata_i = '0;
        bus.mem_rdy_i   = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",   32'(bus.busy_o),    32'd0);
        chk("rst_gnt",    32'(bus.gnt_o),     32'd0);
        chk("rst_memval", 32'(bus.mem_val_o), 32'd0);
        chk("rst_rdy",    32'(bus.req_rdy_o), 32'd0);
        chk("rst_rspval", 32'(bus.rsp_val_o), 32'd0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 6; i++) run_single(vecs[i]);

        // Contention: pointer is back at 0, all three read continuously.
        bus.req_addr_i[0] = 8'h10;
        bus.req_addr_i[1] = 8'h11;
        bus.req_addr_i[2] = 8'h12;
        for (int k = 0; k < 6; k++) begin
            exp_order[k] = k % 3;
            exp_gap[k]   = 3;
            exp_data[k]  = (k % 3 == 0) ? 16'h0F0F : (k % 3 == 1) ? 16'hA5A5 : 16'h5555;
        end
        bus.req_val_i = 3'b111;
        observe(6);

        // Backpressure on a write from req0.
        wait_idle();
        bus.mem_rdy_i      = 1'b0;
        bus.req_val_i[0]   = 1'b1;
        bus.req_wen_i[0]   = 1'b1;
        bus.req_addr_i[0]  = 8'h20;
        bus.req_wdata_i[0] = 16'hBEEF;
        for (int c = 0; c < 4; c++) begin
            step();
            chk("bp_rdy",   32'(bus.req_rdy_o),   32'd0);
            chk("bp_val",   32'(bus.mem_val_o),   32'd1);
            chk("bp_addr",  32'(bus.mem_addr_o),  32'h20);
            chk("bp_wdata", 32'(bus.mem_wdata_o), 32'hBEEF);
        end
        bus.mem_rdy_i = 1'b1;
        #1;
        chk("bp_rdy5", 32'(bus.req_rdy_o), 32'd1);
        step();
        drop_all();
        chk("bp_norsp", 32'(bus.rsp_val_o), 32'd0);
        step();
        run_single('{0, 1'b0, 8'h20, 16'h0000, 16'hBEEF});

        // Lock: ptr is 1, req1 locked wins three times, then req0.
        bus.req_addr_i[0] = 8'h10;
        bus.req_addr_i[1] = 8'h12;
        exp_order[0] = 1; exp_gap[0] = 0; exp_data[0] = 16'h5555;
        exp_order[1] = 1; exp_gap[1] = 2; exp_data[1] = 16'h5555;
        exp_order[2] = 1; exp_gap[2] = 2; exp_data[2] = 16'h5555;
        exp_order[3] = 0; exp_gap[3] = 3; exp_data[3] = 16'h0F0F;
        bus.req_lock_i = 3'b010;
        bus.req_val_i  = 3'b011;
        observe(4);

        // Reset while req2 is stalled in BUSY; ptr would otherwise favour req1.
        wait_idle();
        bus.mem_rdy_i    = 1'b0;
        bus.req_val_i[2] = 1'b1;
        step();
        chk("rst_mid_gnt", 32'(bus.gnt_o), 32'b100);
        rst_n = 1'b0;
        step();
        chk("rst_mid_memval", 32'(bus.mem_val_o), 32'd0);
        chk("rst_mid_gnt0",   32'(bus.gnt_o),     32'd0);
        chk("rst_mid_rspval", 32'(bus.rsp_val_o), 32'd0);
        rst_n = 1'b1;
        bus.mem_rdy_i = 1'b1;
        exp_order[0] = 0; exp_gap[0] = 0; exp_data[0] = 16'h0F0F;
        bus.req_val_i = 3'b111;
        observe(1);

        // Withdrawal: req2 drops before accept; ptr stays 1 so req2 beats req0 next.
        wait_idle();
        bus.mem_rdy_i    = 1'b0;
        bus.req_val_i[2] = 1'b1;
        step();
        chk("wd_gnt", 32'(bus.gnt_o),     32'b100);
        chk("wd_rdy", 32'(bus.req_rdy_o), 32'd0);
        bus.req_val_i[2] = 1'b0;
        step();
        chk("wd_idle",   32'(bus.busy_o),    32'd0);
        chk("wd_norsp",  32'(bus.rsp_val_o), 32'd0);
        bus.mem_rdy_i = 1'b1;
        exp_order[0] = 2; exp_gap[0] = 0; exp_data[0] = 16'h5555;
        bus.req_val_i = 3'b101;
        observe(1);

        repeat (3) step();
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
